// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared definitions for the Data_Memory arbiter:
//     - FSM state encoding (IDLE -> ACCESS -> RESP)
//     - requester port identifiers (CPU load/store = 0, DMA/debug = 1)
//     - default bus widths and memory depth
//   Optional build macro used elsewhere in this slice: DMARB_ROUND_ROBIN_EN
//   (round-robin tie breaking in dmem_arb_pick).
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 32;
  localparam int MEM_DEPTH_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_id_t;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   One requester-side req/ack channel of the Data_Memory arbiter.
//   The arbiter instantiates two of these (CPU and DMA/debug).
//   Signals:
//     req    request valid; we/addr/wdata held stable until ack
//     we     1 = write, 0 = read
//     addr   word address
//     wdata  write data
//     ack    one-cycle completion pulse
//     rdata  read data, valid with ack, held until the next ack
//     err    valid with ack; 1 = address outside the memory
//   Modports:
//     master  requester side (drives req/we/addr/wdata)
//     slave   arbiter side   (drives ack/rdata/err)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, err
  );

endinterface : dmem_arbiter_if

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
//   Combinational two-way picker: chooses which requester is granted when
//   the arbiter is idle.
//   Ports:
//     req0        in  request from port 0 (CPU)
//     req1        in  request from port 1 (DMA/debug)
//     last_grant  in  port granted most recently
//     grant       out winning port id (PORT_CPU when nothing requests)
//   Build option:
//     DMARB_ROUND_ROBIN_EN defined   -> on a tie the port not granted last wins
//     DMARB_ROUND_ROBIN_EN undefined -> fixed priority, port 0 always wins ties
//                                       (port 1 can starve under continuous
//                                       port 0 traffic)
// -----------------------------------------------------------------------------
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_t last_grant,
  output port_id_t grant
);

`ifdef DMARB_ROUND_ROBIN_EN

  // NOTE: grant gets a default before any branch so every path assigns it and
  // no latch is inferred.
  always_comb begin
    grant = PORT_CPU;
    if (req0 && req1) begin
      grant = (last_grant == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else if (req1) begin
      grant = PORT_DMA;
    end
  end

`else

  // History is irrelevant with fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = PORT_CPU;
    if (req1 && !req0) begin
      grant = PORT_DMA;
    end
  end

`endif

endmodule : dmem_arb_pick

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port Data_Memory between the CPU MEM stage (port 0) and
//   the DMA/debug bridge (port 1). Each transaction takes three cycles:
//     IDLE   : pick a winner, latch its id/we/addr/wdata
//     ACCESS : drive the memory from the latch; the memory writes at the
//              closing edge; read data and range error are captured
//     RESP   : one-cycle ack to the winner
//   Addresses >= MEM_DEPTH never write, read back 0 and return err = 1.
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   synchronous active-high reset
//     port0    slave channel for the CPU requester
//     port1    slave channel for the DMA/debug requester
//     busy     out  FSM not in IDLE
//     mem_we   out  Data_Memory WE (only in ACCESS, in range, not in reset)
//     mem_a    out  Data_Memory A  (holds last latched address)
//     mem_wd   out  Data_Memory WD (holds last latched write data)
//     mem_rd   in   Data_Memory RD (combinational read)
//   Build option: DMARB_ROUND_ROBIN_EN selects round-robin tie breaking
//   (see dmem_arb_pick); default is fixed priority to port 0.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     port0,
  dmem_arbiter_if.slave     port1,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_nxt;

  port_id_t          grant;
  port_id_t          last_grant;
  logic              any_req;

  // Latched winning request
  port_id_t          lat_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              in_range;
  logic [DATA_W-1:0] access_rdata;

  // Per-port response registers
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              err0_q;
  logic              err1_q;

  assign any_req = port0.req | port1.req;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  dmem_arb_pick u_pick (
    .req0       (port0.req),
    .req1       (port1.req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    port0.ack = 1'b0;
    port1.ack = 1'b0;
    mem_we    = 1'b0;
    busy      = (state != ST_IDLE);
    unique case (state)
      ST_ACCESS: begin
        // The memory writes on the edge that closes ACCESS; a reset seen in
        // the same cycle must abort that write, so rst gates WE directly.
        mem_we = lat_we & in_range & ~rst;
      end
      ST_RESP: begin
        port0.ack = (lat_id == PORT_CPU);
        port1.ack = (lat_id == PORT_DMA);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory interface: driven straight from the latch, so A/WD hold their last
  // value outside ACCESS.
  // ---------------------------------------------------------------------------
  assign mem_a        = lat_addr;
  assign mem_wd       = lat_wdata;
  assign in_range     = (lat_addr < DEPTH_A);
  assign access_rdata = in_range ? mem_rd : '0;

  // ---------------------------------------------------------------------------
  // Request latch, priority history and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_id     <= PORT_CPU;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      // History says "port 1 went last", so the first tie after reset goes
      // to port 0 when round-robin is enabled.
      last_grant <= PORT_DMA;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && any_req) begin
        lat_id     <= grant;
        last_grant <= grant;
        if (grant == PORT_DMA) begin
          lat_we    <= port1.we;
          lat_addr  <= port1.addr;
          lat_wdata <= port1.wdata;
        end else begin
          lat_we    <= port0.we;
          lat_addr  <= port0.addr;
          lat_wdata <= port0.wdata;
        end
      end

      // Only the winner's response registers move; the other port keeps the
      // data from its own last transaction.
      if (state == ST_ACCESS) begin
        if (lat_id == PORT_DMA) begin
          rdata1_q <= access_rdata;
          err1_q   <= ~in_range;
        end else begin
          rdata0_q <= access_rdata;
          err0_q   <= ~in_range;
        end
      end
    end
  end

  assign port0.rdata = rdata0_q;
  assign port0.err   = err0_q;
  assign port1.rdata = rdata1_q;
  assign port1.err   = err1_q;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. A behavioural Data_Memory sits on
//   the memory port; a shadow copy of the memory predicts read data. Expected
//   responses are queued per port when a request is driven and compared when
//   that port acks. Honours DMARB_ROUND_ROBIN_EN for the tie-breaking cases.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  logic          busy;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .port0  (if0),
    .port1  (if1),
    .busy   (busy),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  // Behavioural Data_Memory: combinational read, write on the rising edge.
  // Outside the array it returns garbage so a missing range gate shows up.
  bit [DW-1:0] mem   [0:DEPTH-1];
  bit [DW-1:0] model [0:DEPTH-1];

  assign mem_rd = (mem_a < DEPTH_A) ? mem[mem_a[9:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_we && (mem_a < DEPTH_A)) mem[mem_a[9:0]] <= mem_wd;
  end

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int n_vec    = 0;
  int n_miss   = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  bit we_seen  = 1'b0;
  bit busy_hist [0:16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) we_seen = 1'b1;
    if ((if0.ack === 1'b1) && (if1.ack === 1'b1)) check("dual ack", 1, 0);
    if (if0.ack === 1'b1) begin
      ack0_cnt++;
      if (q0.size() == 0) check("ack0 unexpected", 1, 0);
      else begin
        e0 = q0.pop_front();
        if (!e0.we) check("rdata0", if0.rdata, e0.rdata);
        check("err0", if0.err, e0.err);
      end
    end
    if (if1.ack === 1'b1) begin
      ack1_cnt++;
      if (q1.size() == 0) check("ack1 unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        if (!e1.we) check("rdata1", if1.rdata, e1.rdata);
        check("err1", if1.err, e1.err);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic slot();
    @(posedge clk);
    #1;
  endtask

  // Present a request; with track=1 the expected response is queued and the
  // shadow memory updated.
  task automatic drive(input bit p, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input bit track);
    exp_t e;
    bit   inr;
    inr     = (a < DEPTH_A);
    e.we    = we;
    e.err   = !inr;
    e.rdata = (inr && !we) ? model[a[9:0]] : '0;
    if (track) begin
      if (we && inr) model[a[9:0]] = wd;
      if (p) q1.push_back(e);
      else   q0.push_back(e);
    end
    if (p) begin
      if1.req = 1'b1; if1.we = we; if1.addr = a; if1.wdata = wd;
    end else begin
      if0.req = 1'b1; if0.we = we; if0.addr = a; if0.wdata = wd;
    end
  endtask

  // Count rising edges after the request edge until the wanted acks are seen.
  // A port that has acked drops its request in the following cycle.
  task automatic wait_acks(input bit w0, input bit w1, input string tag,
                           output int t0, output int t1);
    t0 = -1;
    t1 = -1;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #1;
      if (t0 >= 0) if0.req = 1'b0;
      if (t1 >= 0) if1.req = 1'b0;
      @(negedge clk);
      busy_hist[n] = busy;
      if ((if0.ack === 1'b1) && (t0 < 0)) t0 = n;
      if ((if1.ack === 1'b1) && (t1 < 0)) t1 = n;
      if ((!w0 || t0 >= 0) && (!w1 || t1 >= 0)) break;
    end
    if (w0 && t0 < 0) check({tag, " ack0 timeout"}, 0, 1);
    if (w1 && t1 < 0) check({tag, " ack1 timeout"}, 0, 1);
  endtask

  task automatic release_all();
    slot();
    if0.req = 1'b0;
    if1.req = 1'b0;
  endtask

  // Single transaction on one port, latency checked.
  task automatic single(input bit p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input string tag);
    int t0, t1;
    drive(p, we, a, wd, 1'b1);
    wait_acks(!p, p, tag, t0, t1);
    check({tag, " latency"}, p ? t1 : t0, 2);
    release_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t0, t1, a1;
    rst = 1'b1;
    if0.req = 1'b0; if0.we = 1'b0; if0.addr = '0; if0.wdata = '0;
    if1.req = 1'b0; if1.we = 1'b0; if1.addr = '0; if1.wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ack0",   if0.ack,   0);
    check("rst ack1",   if1.ack,   0);
    check("rst busy",   busy,      0);
    check("rst mem_we", mem_we,    0);
    check("rst rdata0", if0.rdata, 0);
    check("rst rdata1", if1.rdata, 0);
    check("rst err0",   if0.err,   0);
    check("rst err1",   if1.err,   0);
    check("rst mem_a",  mem_a,     0);
    check("rst mem_wd", mem_wd,    0);
    slot();
    rst = 1'b0;

    // 1: port 0 write then read back
    a1 = ack1_cnt;
    slot();
    single(0, 1, 42, 32'h20, "t1 wr");
    single(0, 0, 42, 32'h0,  "t1 rd");
    check("t1 ack1 quiet", ack1_cnt, a1);

    // 2: port 1 write, port 0 read, busy profile
    slot();
    drive(1, 1, 42, 32'h2, 1'b1);
    @(negedge clk);
    check("t2 busy before sample", busy, 0);
    wait_acks(0, 1, "t2 wr", t0, t1);
    check("t2 latency", t1, 2);
    check("t2 busy c1", busy_hist[1], 1);
    check("t2 busy c2", busy_hist[2], 1);
    release_all();
    @(negedge clk);
    check("t2 busy idle", busy, 0);
    slot();
    single(0, 0, 42, 32'h0, "t2 rd");

    // 3: simultaneous requests
    single(0, 1, 10, 32'h1010, "t3 pre0");
    single(1, 1, 20, 32'h2020, "t3 pre1");
    drive(0, 0, 10, 32'h0, 1'b1);
    drive(1, 0, 20, 32'h0, 1'b1);
    wait_acks(1, 1, "t3 tie", t0, t1);
    check("t3 tie ack0 time", t0, 2);
    check("t3 tie ack1 time", t1, 5);
    release_all();
`ifdef DMARB_ROUND_ROBIN_EN
    single(0, 0, 10, 32'h0, "t3 mid");
    drive(0, 0, 10, 32'h0, 1'b1);
    drive(1, 0, 20, 32'h0, 1'b1);
    wait_acks(1, 1, "t3 tie2", t0, t1);
    check("t3 tie2 ack1 time", t1, 2);
    check("t3 tie2 ack0 time", t0, 5);
    release_all();
`endif

    // 4: out-of-range write and read
    we_seen = 1'b0;
    single(0, 1, 1024, 32'hDEAD, "t4 wr");
    check("t4 mem_we suppressed", we_seen, 0);
    single(0, 0, 1024, 32'h0, "t4 rd");
    single(1, 0, 0,    32'h0, "t4 alias");

    // 5: reset during ACCESS aborts the write
    a1 = ack1_cnt;
    slot();
    drive(1, 1, 7, 32'h55, 1'b0);
    slot();
    rst = 1'b1;
    @(negedge clk);
    check("t5 mem_we in rst", mem_we, 0);
    slot();
    rst = 1'b0;
    if1.req = 1'b0;
    @(negedge clk);
    check("t5 idle after rst", busy, 0);
    repeat (4) @(negedge clk);
    check("t5 no ack1", ack1_cnt, a1);
    check("t5 mem[7] untouched", mem[7], 0);
    slot();
    single(1, 0, 7, 32'h0, "t5 rd");

`ifndef DMARB_ROUND_ROBIN_EN
    // 6: port 1 starves under continuous port 0 traffic
    a1 = ack1_cnt;
    slot();
    drive(1, 0, 20, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 10, 32'h0, 1'b1);
      wait_acks(1, 0, "t6 cpu", t0, t1);
      check("t6 cpu latency", t0, 2);
      slot();
    end
    check("t6 ack1 starved", ack1_cnt, a1);
    if0.req = 1'b0;
    wait_acks(0, 1, "t6 dma", t0, t1);
    check("t6 dma served", t1, 2);
    release_all();
`endif

    repeat (3) @(negedge clk);
    check("q0 drained", q0.size(), 0);
    check("q1 drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_dmem_arbiter
